// File: rtl/pc_sequencer.sv
// pc_sequencer: Moore FSM that drives an external program counter through LOAD/FETCH/UPDATE.
// Optional fetch-wait timeout is built when PC_SEQ_TIMEOUT_EN is defined.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR   = 16'h0000,
  parameter logic [15:0] END_ADDR       = 16'h00FF,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        branch_req,
  input  logic [15:0] branch_target,
  input  logic        mem_ready,
  input  logic [15:0] pc_value,
  output logic        pc_write,
  output logic        pc_inc,
  output logic [15:0] pc_load_value,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] retired
);

  // state  | meaning
  // IDLE   | waiting for start after reset, all outputs low
  // LOAD   | one-cycle PC load of RESET_VECTOR
  // FETCH  | fetch request held at pc_value until mem_ready
  // UPDATE | one-cycle PC branch-load or increment, retire count
  // HALT   | run finished (done=1), start restarts
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, UPDATE, HALT} state_t;

  state_t      state, state_nxt;
  logic        br_q;
  logic [15:0] tgt_q;
  logic [15:0] last_q;
  logic        halt_pending;
  logic [15:0] retired_q;
  logic        timeout;
  logic        fetch_done;
  logic        run_start;

  assign fetch_done = (state == FETCH) && mem_ready;
  assign run_start  = start && ((state == IDLE) || (state == HALT));
  assign retired    = retired_q;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       error_q;

  // Down-counter reloads whenever a fetch is not actively stalling.
  assign timeout = (state == FETCH) && !mem_ready && (wait_cnt == 8'd0);
  assign error   = error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= WAIT_LAST;
      error_q  <= 1'b0;
    end else begin
      if ((state == FETCH) && !mem_ready && !timeout) wait_cnt <= wait_cnt - 8'd1;
      else                                            wait_cnt <= WAIT_LAST;
      if (run_start)    error_q <= 1'b0;
      else if (timeout) error_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      br_q         <= 1'b0;
      tgt_q        <= 16'h0000;
      last_q       <= 16'h0000;
      halt_pending <= 1'b0;
      retired_q    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (fetch_done) begin
        br_q   <= branch_req;
        tgt_q  <= branch_target;
        last_q <= pc_value;
      end
      if (run_start)             halt_pending <= 1'b0;
      else if (halt_req && busy) halt_pending <= 1'b1;
      if (run_start)
        retired_q <= 16'h0000;
      else if ((state == UPDATE) && (retired_q != 16'hFFFF))
        retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LOAD;
      LOAD:   state_nxt = FETCH;
      FETCH: begin
        if (mem_ready)    state_nxt = UPDATE;
        else if (timeout) state_nxt = HALT;
      end
      // A pending branch outranks the end-of-range stop.
      UPDATE: begin
        if (halt_pending || (!br_q && (last_q == END_ADDR))) state_nxt = HALT;
        else                                                 state_nxt = FETCH;
      end
      HALT:   if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_inc        = 1'b0;
    pc_load_value = 16'h0000;
    fetch_req     = 1'b0;
    fetch_addr    = 16'h0000;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      LOAD: begin
        pc_write      = 1'b1;
        pc_load_value = RESET_VECTOR;
        busy          = 1'b1;
      end
      FETCH: begin
        fetch_req  = 1'b1;
        fetch_addr = pc_value;
        busy       = 1'b1;
      end
      UPDATE: begin
        busy = 1'b1;
        if (br_q) begin
          pc_write      = 1'b1;
          pc_load_value = tgt_q;
        end else if (last_q != END_ADDR) begin
          pc_inc = 1'b1;
        end
      end
      HALT:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
